// File: rtl/multicycle_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and constants for the multi-cycle control
// sequencer (state encoding, opcode/funct values, ALU and PC-source codes,
// decode and output bundles) plus small decode helper functions.
package mips_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_XOR  = 3'd2,
      ALU_SLT  = 3'd3,
      ALU_AND  = 3'd4,
      ALU_NAND = 3'd5,
      ALU_NOR  = 3'd6,
      ALU_OR   = 3'd7
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2,
      PC_REG    = 2'd3
   } pc_src_e;

   // Instruction class produced by the decoder; drives FSM sequencing.
   typedef enum logic [3:0] {
      CLS_RALU = 4'd0,
      CLS_JR   = 4'd1,
      CLS_LW   = 4'd2,
      CLS_SW   = 4'd3,
      CLS_J    = 4'd4,
      CLS_JAL  = 4'd5,
      CLS_BEQ  = 4'd6,
      CLS_BNE  = 4'd7,
      CLS_ADDI = 4'd8,
      CLS_XORI = 4'd9,
      CLS_ILL  = 4'd10
   } instr_cls_e;

   // Decoded control bundle; the static fields are held through EXEC/MEM/WB.
   typedef struct packed {
      logic       legal;
      instr_cls_e cls;
      logic       reg_dst;
      logic       alu_src;
      logic       zero_ext;
      alu_ctrl_e  alu_ctrl;
   } decode_t;

   // Everything the sequencer drives toward the datapath and memory.
   typedef struct packed {
      logic      mem_req;
      logic      mem_wr;
      logic      ir_wr;
      logic      pc_wr;
      pc_src_e   pc_src;
      logic      reg_wr;
      logic      reg_dst;
      logic      alu_src;
      logic      mem_to_reg;
      logic      jal;
      logic      jr;
      logic      branch;
      logic      zero_ext;
      alu_ctrl_e alu_ctrl;
      logic      illegal;
   } ctrl_out_t;

   // ALU operation for a legal R-type arithmetic funct.
   function automatic alu_ctrl_e alu_from_funct(input logic [5:0] funct);
      alu_ctrl_e a;
      case (funct)
         FN_ADD:  a = ALU_ADD;
         FN_SUB:  a = ALU_SUB;
         FN_SLT:  a = ALU_SLT;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   // Branch outcome: BEQ takes on zero, BNE on not-zero.
   function automatic logic branch_taken(input instr_cls_e cls, input logic zero);
      logic t;
      case (cls)
         CLS_BEQ: t = zero;
         CLS_BNE: t = ~zero;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

   // Copy the decode-time datapath controls into an output bundle.
   function automatic ctrl_out_t apply_held(input ctrl_out_t o, input decode_t d);
      ctrl_out_t r;
      r          = o;
      r.reg_dst  = d.reg_dst;
      r.alu_src  = d.alu_src;
      r.zero_ext = d.zero_ext;
      r.alu_ctrl = d.alu_ctrl;
      return r;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: shared-memory request/acknowledge handshake between the
// control sequencer (master) and the memory (slave).
interface multicycle_ctrl_if;
   logic mem_req;
   logic mem_wr;
   logic mem_ack;

   modport master (output mem_req, output mem_wr, input mem_ack);
   modport slave  (input mem_req, input mem_wr, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder. Maps opcode/funct
// to an instruction class, the static datapath controls and a legal flag.
module ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output decode_t    dec
);

   // Decode opcode (and funct for R-type) into the control bundle.
   always_comb begin
      dec       = '0;
      dec.cls   = CLS_ILL;
      dec.legal = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_SLT: begin
                  dec.legal    = 1'b1;
                  dec.cls      = CLS_RALU;
                  dec.reg_dst  = 1'b1;
                  dec.alu_ctrl = alu_from_funct(funct);
               end
               FN_JR: begin
                  dec.legal = 1'b1;
                  dec.cls   = CLS_JR;
               end
               default: begin
                  dec.legal = 1'b0;
                  dec.cls   = CLS_ILL;
               end
            endcase
         end
         OP_LW: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_LW;
            dec.alu_src  = 1'b1;
            dec.alu_ctrl = ALU_ADD;
         end
         OP_SW: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_SW;
            dec.alu_src  = 1'b1;
            dec.alu_ctrl = ALU_ADD;
         end
         OP_J: begin
            dec.legal = 1'b1;
            dec.cls   = CLS_J;
         end
         OP_JAL: begin
            dec.legal = 1'b1;
            dec.cls   = CLS_JAL;
         end
         OP_BEQ: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_BEQ;
            dec.alu_ctrl = ALU_SUB;
         end
         OP_BNE: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_BNE;
            dec.alu_ctrl = ALU_SUB;
         end
         OP_ADDI: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_ADDI;
            dec.alu_src  = 1'b1;
            dec.alu_ctrl = ALU_ADD;
         end
         OP_XORI: begin
            dec.legal    = 1'b1;
            dec.cls      = CLS_XORI;
            dec.alu_src  = 1'b1;
            dec.zero_ext = 1'b1;
            dec.alu_ctrl = ALU_XOR;
         end
         default: begin
            dec.legal = 1'b0;
            dec.cls   = CLS_ILL;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer
// for the MIPS-subset datapath. Optional performance counters are built
// only when the macro CTRL_PERF_EN is defined; otherwise the counter ports
// read 0 and no counter flops exist.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_ctrl_if.master    mem,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic                 zero,
   output logic                 ir_wr,
   output logic                 pc_wr,
   output logic [1:0]           pc_src,
   output logic                 reg_wr,
   output logic                 reg_dst,
   output logic                 ALU_src,
   output logic                 mem_to_reg,
   output logic                 jal,
   output logic                 jr,
   output logic                 branch,
   output logic                 zero_ext,
   output logic [2:0]           ALU_ctrl,
   output logic                 illegal,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     instr_count
);

   state_e    state_q, state_d;
   decode_t   dec_s;
   ctrl_out_t out_s;
   ctrl_out_t out_g;

   ctrl_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .dec    (dec_s)
   );

   // State register; reset lands in FETCH.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and control outputs (Mealy on mem_ack/zero where required).
   always_comb begin
      state_d = state_q;
      out_s   = '0;
      case (state_q)
         S_FETCH: begin
            out_s.mem_req = 1'b1;
            if (mem.mem_ack) begin
               out_s.ir_wr = 1'b1;
               state_d     = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if (!dec_s.legal) begin
               state_d = S_TRAP;
            end else begin
               case (dec_s.cls)
                  CLS_J: begin
                     out_s.pc_wr  = 1'b1;
                     out_s.pc_src = PC_JUMP;
                     state_d      = S_FETCH;
                  end
                  CLS_JAL: begin
                     out_s.pc_wr  = 1'b1;
                     out_s.pc_src = PC_JUMP;
                     out_s.jal    = 1'b1;
                     out_s.reg_wr = 1'b1;
                     state_d      = S_FETCH;
                  end
                  CLS_JR: begin
                     out_s.pc_wr  = 1'b1;
                     out_s.pc_src = PC_REG;
                     out_s.jr     = 1'b1;
                     state_d      = S_FETCH;
                  end
                  default: begin
                     state_d = S_EXEC;
                  end
               endcase
            end
         end
         S_EXEC: begin
            out_s = apply_held(out_s, dec_s);
            case (dec_s.cls)
               CLS_BEQ, CLS_BNE: begin
                  out_s.branch = 1'b1;
                  out_s.pc_wr  = 1'b1;
                  out_s.pc_src = branch_taken(dec_s.cls, zero) ? PC_BRANCH : PC_SEQ;
                  state_d      = S_FETCH;
               end
               CLS_LW, CLS_SW: begin
                  state_d = S_MEM;
               end
               default: begin
                  state_d = S_WB;
               end
            endcase
         end
         S_MEM: begin
            out_s         = apply_held(out_s, dec_s);
            out_s.mem_req = 1'b1;
            out_s.mem_wr  = (dec_s.cls == CLS_SW);
            if (mem.mem_ack) begin
               if (dec_s.cls == CLS_SW) begin
                  out_s.pc_wr  = 1'b1;
                  out_s.pc_src = PC_SEQ;
                  state_d      = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else begin
               state_d = S_MEM;
            end
         end
         S_WB: begin
            out_s            = apply_held(out_s, dec_s);
            out_s.reg_wr     = 1'b1;
            out_s.mem_to_reg = (dec_s.cls == CLS_LW);
            out_s.pc_wr      = 1'b1;
            out_s.pc_src     = PC_SEQ;
            state_d          = S_FETCH;
         end
         S_TRAP: begin
            out_s.illegal = 1'b1;
            state_d       = S_TRAP;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Force every output low while reset is held, dropping any in-flight request.
   always_comb begin
      if (reset) begin
         out_g = '0;
      end else begin
         out_g = out_s;
      end
   end

   assign mem.mem_req = out_g.mem_req;
   assign mem.mem_wr  = out_g.mem_wr;
   assign ir_wr       = out_g.ir_wr;
   assign pc_wr       = out_g.pc_wr;
   assign pc_src      = out_g.pc_src;
   assign reg_wr      = out_g.reg_wr;
   assign reg_dst     = out_g.reg_dst;
   assign ALU_src     = out_g.alu_src;
   assign mem_to_reg  = out_g.mem_to_reg;
   assign jal         = out_g.jal;
   assign jr          = out_g.jr;
   assign branch      = out_g.branch;
   assign zero_ext    = out_g.zero_ext;
   assign ALU_ctrl    = out_g.alu_ctrl;
   assign illegal     = out_g.illegal;

`ifdef CTRL_PERF_EN
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] ins_q, ins_d;

   // Counter increments: cycles outside TRAP, instructions on each PC update.
   always_comb begin
      if (state_q != S_TRAP) begin
         cyc_d = cyc_q + CNT_W'(1'b1);
      end else begin
         cyc_d = cyc_q;
      end
      if (out_s.pc_wr) begin
         ins_d = ins_q + CNT_W'(1'b1);
      end else begin
         ins_d = ins_q;
      end
   end

   // Performance counter registers, cleared by reset, wrapping naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ins_q <= ins_d;
      end
   end

   assign cycle_count = cyc_q;
   assign instr_count = ins_q;
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Inputs change just after the falling edge; outputs are sampled 1 time unit
// later, well away from the rising (active) edge.
module tb_multicycle_ctrl;

   localparam int CNT_W = 32;

   logic             clk;
   logic             reset;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic             zero;
   logic             ir_wr, pc_wr, reg_wr, reg_dst, ALU_src, mem_to_reg;
   logic             jal, jr, branch, zero_ext, illegal;
   logic [1:0]       pc_src;
   logic [2:0]       ALU_ctrl;
   logic [CNT_W-1:0] cycle_count, instr_count;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl_if mif ();

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem         (mif),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .ir_wr       (ir_wr),
      .pc_wr       (pc_wr),
      .pc_src      (pc_src),
      .reg_wr      (reg_wr),
      .reg_dst     (reg_dst),
      .ALU_src     (ALU_src),
      .mem_to_reg  (mem_to_reg),
      .jal         (jal),
      .jr          (jr),
      .branch      (branch),
      .zero_ext    (zero_ext),
      .ALU_ctrl    (ALU_ctrl),
      .illegal     (illegal),
      .cycle_count (cycle_count),
      .instr_count (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed output vector, bit order matches ev() below.
   logic [17:0] obs;
   assign obs = {mif.mem_req, mif.mem_wr, ir_wr, pc_wr, pc_src, reg_wr, reg_dst,
                 ALU_src, mem_to_reg, jal, jr, branch, zero_ext, ALU_ctrl, illegal};

   function automatic logic [17:0] ev(input logic mreq, input logic mwr, input logic irw,
                                      input logic pcw, input logic [1:0] ps, input logic rw,
                                      input logic rd, input logic as, input logic m2r,
                                      input logic jl, input logic jrr, input logic br,
                                      input logic zx, input logic [2:0] alu, input logic ill);
      return {mreq, mwr, irw, pcw, ps, rw, rd, as, m2r, jl, jrr, br, zx, alu, ill};
   endfunction

   logic [17:0] E_ZERO, E_FWAIT, E_FACK, E_ILL;

   task automatic test_reset();
      reset = 1'b1; mif.mem_ack = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
      @(negedge clk); #1;
      checks++;
      if (obs !== E_ZERO) begin
         errors++; $display("FAIL reset_outputs: got %h expected %h", obs, E_ZERO);
      end
      checks++;
      if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
         errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
      end
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if (obs !== E_FWAIT) begin
         errors++; $display("FAIL reset_release_fetch: got %h expected %h", obs, E_FWAIT);
      end
   endtask

   // ADD with zero-wait memory; mem_ack held high outside FETCH must be ignored.
   task automatic test_add();
      logic        ack [5];
      logic [17:0] ex  [5];
      logic [31:0] exp_cyc, exp_ins;
      ack = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      ex[0] = E_FACK;
      ex[1] = E_ZERO;
      ex[2] = ev(0,0,0,0,2'd0, 0,1,0,0, 0,0,0,0, 3'd0, 0);
      ex[3] = ev(0,0,0,1,2'd0, 1,1,0,0, 0,0,0,0, 3'd0, 0);
      ex[4] = E_FWAIT;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mif.mem_ack = ack[i]; opcode = 6'h00; funct = 6'h20; zero = 1'b0;
         #1;
         checks++;
         if (obs !== ex[i]) begin
            errors++; $display("FAIL add row %0d: got %h expected %h", i, obs, ex[i]);
         end
      end
`ifdef CTRL_PERF_EN
      exp_cyc = 32'd5; exp_ins = 32'd1;
`else
      exp_cyc = 32'd0; exp_ins = 32'd0;
`endif
      checks++;
      if (cycle_count !== exp_cyc || instr_count !== exp_ins) begin
         errors++; $display("FAIL add_counters: got %0d/%0d expected %0d/%0d",
                            cycle_count, instr_count, exp_cyc, exp_ins);
      end
   endtask

   // LW with two wait cycles in FETCH and in MEM: nine cycles total.
   task automatic test_lw_wait();
      logic        ack [10];
      logic [17:0] ex  [10];
      logic [17:0] e_mem;
      ack = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      e_mem = ev(1,0,0,0,2'd0, 0,0,1,0, 0,0,0,0, 3'd0, 0);
      ex[0] = E_FWAIT; ex[1] = E_FWAIT; ex[2] = E_FACK; ex[3] = E_ZERO;
      ex[4] = ev(0,0,0,0,2'd0, 0,0,1,0, 0,0,0,0, 3'd0, 0);
      ex[5] = e_mem; ex[6] = e_mem; ex[7] = e_mem;
      ex[8] = ev(0,0,0,1,2'd0, 1,0,1,1, 0,0,0,0, 3'd0, 0);
      ex[9] = E_FWAIT;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         mif.mem_ack = ack[i]; opcode = 6'h23; funct = 6'h00; zero = 1'b0;
         #1;
         checks++;
         if (obs !== ex[i]) begin
            errors++; $display("FAIL lw_wait row %0d: got %h expected %h", i, obs, ex[i]);
         end
      end
   endtask

   // BEQ zero=1 (taken), BNE zero=1 (not taken), BNE zero=0 (taken).
   task automatic test_branch();
      logic [5:0]  op  [10];
      logic        zr  [10];
      logic        ack [10];
      logic [17:0] ex  [10];
      op  = '{6'h04, 6'h04, 6'h04, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h05, 6'h00};
      zr  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      ack = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      ex[0] = E_FACK; ex[1] = E_ZERO;
      ex[2] = ev(0,0,0,1,2'd1, 0,0,0,0, 0,0,1,0, 3'd1, 0);
      ex[3] = E_FACK; ex[4] = E_ZERO;
      ex[5] = ev(0,0,0,1,2'd0, 0,0,0,0, 0,0,1,0, 3'd1, 0);
      ex[6] = E_FACK; ex[7] = E_ZERO;
      ex[8] = ev(0,0,0,1,2'd1, 0,0,0,0, 0,0,1,0, 3'd1, 0);
      ex[9] = E_FWAIT;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         mif.mem_ack = ack[i]; opcode = op[i]; funct = 6'h00; zero = zr[i];
         #1;
         checks++;
         if (obs !== ex[i]) begin
            errors++; $display("FAIL branch row %0d: got %h expected %h", i, obs, ex[i]);
         end
      end
   endtask

   // JAL, JR, J: two cycles each, PC updated in DECODE.
   task automatic test_jumps();
      logic [5:0]  op  [7];
      logic [5:0]  fn  [7];
      logic        ack [7];
      logic [17:0] ex  [7];
      op  = '{6'h03, 6'h03, 6'h00, 6'h00, 6'h02, 6'h02, 6'h00};
      fn  = '{6'h00, 6'h00, 6'h08, 6'h08, 6'h00, 6'h00, 6'h20};
      ack = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      ex[0] = E_FACK;
      ex[1] = ev(0,0,0,1,2'd2, 1,0,0,0, 1,0,0,0, 3'd0, 0);
      ex[2] = E_FACK;
      ex[3] = ev(0,0,0,1,2'd3, 0,0,0,0, 0,1,0,0, 3'd0, 0);
      ex[4] = E_FACK;
      ex[5] = ev(0,0,0,1,2'd2, 0,0,0,0, 0,0,0,0, 3'd0, 0);
      ex[6] = E_FWAIT;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         mif.mem_ack = ack[i]; opcode = op[i]; funct = fn[i]; zero = 1'b0;
         #1;
         checks++;
         if (obs !== ex[i]) begin
            errors++; $display("FAIL jumps row %0d: got %h expected %h", i, obs, ex[i]);
         end
      end
   endtask

   // SUB, SLT, ADDI, XORI (4 cycles each) then a zero-wait SW (4 cycles).
   task automatic test_alu_ops();
      logic [5:0]  op  [21];
      logic [5:0]  fn  [21];
      logic [17:0] ex  [21];
      for (int i = 0; i < 21; i++) fn[i] = 6'h00;
      for (int i = 0; i < 4; i++) begin
         op[i] = 6'h00; fn[i] = 6'h22;
         op[4+i] = 6'h00; fn[4+i] = 6'h2A;
         op[8+i] = 6'h08; op[12+i] = 6'h0E; op[16+i] = 6'h2B;
      end
      op[20] = 6'h00;
      ex[0]  = E_FACK; ex[1] = E_ZERO;
      ex[2]  = ev(0,0,0,0,2'd0, 0,1,0,0, 0,0,0,0, 3'd1, 0);
      ex[3]  = ev(0,0,0,1,2'd0, 1,1,0,0, 0,0,0,0, 3'd1, 0);
      ex[4]  = E_FACK; ex[5] = E_ZERO;
      ex[6]  = ev(0,0,0,0,2'd0, 0,1,0,0, 0,0,0,0, 3'd3, 0);
      ex[7]  = ev(0,0,0,1,2'd0, 1,1,0,0, 0,0,0,0, 3'd3, 0);
      ex[8]  = E_FACK; ex[9] = E_ZERO;
      ex[10] = ev(0,0,0,0,2'd0, 0,0,1,0, 0,0,0,0, 3'd0, 0);
      ex[11] = ev(0,0,0,1,2'd0, 1,0,1,0, 0,0,0,0, 3'd0, 0);
      ex[12] = E_FACK; ex[13] = E_ZERO;
      ex[14] = ev(0,0,0,0,2'd0, 0,0,1,0, 0,0,0,1, 3'd2, 0);
      ex[15] = ev(0,0,0,1,2'd0, 1,0,1,0, 0,0,0,1, 3'd2, 0);
      ex[16] = E_FACK; ex[17] = E_ZERO;
      ex[18] = ev(0,0,0,0,2'd0, 0,0,1,0, 0,0,0,0, 3'd0, 0);
      ex[19] = ev(1,1,0,1,2'd0, 0,0,1,0, 0,0,0,0, 3'd0, 0);
      ex[20] = E_FWAIT;
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         mif.mem_ack = (i % 4 == 0 || i == 19) ? 1'b1 : 1'b0;
         if (i == 20) mif.mem_ack = 1'b0;
         opcode = op[i]; funct = fn[i]; zero = 1'b0;
         #1;
         checks++;
         if (obs !== ex[i]) begin
            errors++; $display("FAIL alu_ops row %0d: got %h expected %h", i, obs, ex[i]);
         end
      end
   endtask

   // Illegal opcode traps for 20 cycles; reset recovers; illegal funct also traps.
   task automatic test_illegal();
      logic [17:0] e;
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         mif.mem_ack = (i == 0) ? 1'b1 : ((i % 2 == 1) ? 1'b1 : 1'b0);
         opcode = 6'h3F; funct = 6'h00; zero = 1'b0;
         #1;
         e = (i == 0) ? E_FACK : ((i == 1) ? E_ZERO : E_ILL);
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL illegal_op row %0d: got %h expected %h", i, obs, e);
         end
      end
      @(negedge clk); reset = 1'b1; mif.mem_ack = 1'b0; #1;
      checks++;
      if (obs !== E_ZERO) begin
         errors++; $display("FAIL illegal_reset: got %h expected %h", obs, E_ZERO);
      end
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if (obs !== E_FWAIT) begin
         errors++; $display("FAIL illegal_restart: got %h expected %h", obs, E_FWAIT);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mif.mem_ack = (i == 0) ? 1'b1 : 1'b0;
         opcode = 6'h00; funct = 6'h21; zero = 1'b0;
         #1;
         e = (i == 0) ? E_FACK : ((i == 1) ? E_ZERO : E_ILL);
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL illegal_funct row %0d: got %h expected %h", i, obs, e);
         end
      end
      @(negedge clk); reset = 1'b1; #1;
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if (obs !== E_FWAIT) begin
         errors++; $display("FAIL illegal_funct_restart: got %h expected %h", obs, E_FWAIT);
      end
   endtask

   // Reset while a SW waits in MEM: request drops at once and is not retried.
   task automatic test_reset_mid_sw();
      logic        ack [4];
      logic [17:0] ex  [4];
      ack = '{1'b1, 1'b0, 1'b0, 1'b0};
      ex[0] = E_FACK; ex[1] = E_ZERO;
      ex[2] = ev(0,0,0,0,2'd0, 0,0,1,0, 0,0,0,0, 3'd0, 0);
      ex[3] = ev(1,1,0,0,2'd0, 0,0,1,0, 0,0,0,0, 3'd0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         mif.mem_ack = ack[i]; opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
         #1;
         checks++;
         if (obs !== ex[i]) begin
            errors++; $display("FAIL sw_mid row %0d: got %h expected %h", i, obs, ex[i]);
         end
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (mif.mem_req !== 1'b0 || mif.mem_wr !== 1'b0 || obs !== E_ZERO) begin
         errors++; $display("FAIL sw_mid_reset: got %h expected %h", obs, E_ZERO);
      end
      checks++;
      if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
         errors++; $display("FAIL sw_mid_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
      end
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if (obs !== E_FWAIT) begin
         errors++; $display("FAIL sw_mid_restart: got %h expected %h", obs, E_FWAIT);
      end
   endtask

   initial begin
      reset = 1'b1; mif.mem_ack = 1'b0; zero = 1'b0; opcode = 6'h00; funct = 6'h00;
      E_ZERO  = 18'd0;
      E_FWAIT = ev(1,0,0,0,2'd0, 0,0,0,0, 0,0,0,0, 3'd0, 0);
      E_FACK  = ev(1,0,1,0,2'd0, 0,0,0,0, 0,0,0,0, 3'd0, 0);
      E_ILL   = ev(0,0,0,0,2'd0, 0,0,0,0, 0,0,0,0, 3'd0, 1);
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_jumps();
      test_alu_ops();
      test_illegal();
      test_reset_mid_sw();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
